// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller for the LEGv8 datapath.
// control_word and constant are combinational from state, instruction, status and mem_ready.
module control_sequencer #(
   parameter logic [4:0] FS_ADD = 5'b01000,
   parameter logic [4:0] FS_SUB = 5'b01001,
   parameter int         Z_BIT  = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [3:0]  status,
   input  logic        mem_ready,
   output logic [36:0] control_word,
   output logic [63:0] constant,
   output logic [2:0]  state,
   output logic        halted
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, BRANCH = 3'd3, HALT = 3'd4} state_t;
   typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_ADDI, OP_LDUR, OP_STUR, OP_B, OP_CBZ} op_t;
   state_t cur, nxt;
   op_t op;
   logic [36:0] cw;
   logic [63:0] k;
   logic hlt;
   logic [63:0] d_off, b_off, cb_off;
   logic unused_status;
   assign unused_status = ^status;
   assign d_off  = {{55{instruction[20]}}, instruction[20:12]};
   assign b_off  = {{36{instruction[25]}}, instruction[25:0], 2'b00} - 64'd4;
   assign cb_off = {{43{instruction[23]}}, instruction[23:5], 2'b00} - 64'd4;
   always_comb
      op = instruction[31:21] == 11'b10001011000 ? OP_ADD  :
           instruction[31:21] == 11'b11001011000 ? OP_SUB  :
           instruction[31:22] == 10'b1001000100  ? OP_ADDI :
           instruction[31:21] == 11'b11111000010 ? OP_LDUR :
           instruction[31:21] == 11'b11111000000 ? OP_STUR :
           instruction[31:26] == 6'b000101       ? OP_B    :
           instruction[31:24] == 8'b10110100     ? OP_CBZ  : OP_NONE;
   always_ff @(posedge clock or negedge reset)
      if (!reset) cur <= FETCH;
      else        cur <= nxt;
   // Field map: DA 4:0, SA 9:5, SB 14:10, WR 15, Bsel 16, FS 21:17, C0 22, En_B 23,
   // En_ADDR_ALU 24, En_ALU 25, MR 26, MW 27, size 29:28, SL 30, PCsel 31, EAP 32, IL 34, PS 36:35
   always_comb begin
      cw  = '0;
      k   = '0;
      hlt = 1'b0;
      nxt = cur;
      case (cur)
         FETCH: begin
            cw[32]    = 1'b1;
            cw[26]    = 1'b1;
            cw[29:28] = 2'b11;
            cw[34]    = mem_ready;
            cw[36:35] = mem_ready ? 2'b01 : 2'b00;
            nxt       = mem_ready ? DECODE : FETCH;
         end
         DECODE: nxt = op == OP_NONE ? HALT : EXEC;
         EXEC: begin
            nxt = FETCH;
            case (op)
               OP_ADD, OP_SUB, OP_ADDI: begin
                  cw[4:0]   = instruction[4:0];
                  cw[9:5]   = instruction[9:5];
                  cw[14:10] = op == OP_ADDI ? 5'd0 : instruction[20:16];
                  cw[15]    = 1'b1;
                  cw[16]    = op == OP_ADDI;
                  cw[21:17] = op == OP_SUB ? FS_SUB : FS_ADD;
                  cw[22]    = op == OP_SUB;
                  cw[25]    = 1'b1;
                  cw[30]    = 1'b1;
                  k         = op == OP_ADDI ? {52'd0, instruction[21:10]} : 64'd0;
               end
               OP_LDUR, OP_STUR: begin
                  cw[4:0]   = op == OP_LDUR ? instruction[4:0] : 5'd0;
                  cw[9:5]   = instruction[9:5];
                  cw[14:10] = op == OP_STUR ? instruction[4:0] : 5'd0;
                  cw[15]    = op == OP_LDUR && mem_ready;
                  cw[16]    = 1'b1;
                  cw[21:17] = FS_ADD;
                  cw[23]    = op == OP_STUR;
                  cw[24]    = 1'b1;
                  cw[26]    = op == OP_LDUR;
                  cw[27]    = op == OP_STUR;
                  cw[29:28] = 2'b11;
                  k         = d_off;
                  nxt       = mem_ready ? FETCH : EXEC;
               end
               OP_B: begin
                  cw[31]    = 1'b1;
                  cw[36:35] = 2'b11;
                  k         = b_off;
               end
               OP_CBZ: begin
                  cw[9:5]   = instruction[4:0];
                  cw[16]    = 1'b1;
                  cw[21:17] = FS_ADD;
                  cw[30]    = 1'b1;
                  nxt       = BRANCH;
               end
               default: nxt = FETCH;
            endcase
         end
         BRANCH: begin
            cw[31]    = status[Z_BIT];
            cw[36:35] = status[Z_BIT] ? 2'b11 : 2'b00;
            k         = status[Z_BIT] ? cb_off : 64'd0;
            nxt       = FETCH;
         end
         HALT: hlt = 1'b1;
         default: nxt = FETCH;
      endcase
   end
   // Gating with reset guarantees no memory strobe survives an aborting reset.
   assign control_word = reset ? cw : 37'd0;
   assign constant     = reset ? k : 64'd0;
   assign halted       = reset && hlt;
   assign state        = cur;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of control_sequencer against hand-computed control words.
module tb_control_sequencer;
   logic        clock = 1'b0, reset = 1'b0, mem_ready = 1'b0, halted;
   logic [31:0] instruction = 32'd0;
   logic [3:0]  status = 4'd0;
   logic [36:0] control_word;
   logic [63:0] constant;
   logic [2:0]  state;
   int tests = 0, fails = 0;

   localparam logic [36:0] WR   = 37'd1 << 15, BSEL = 37'd1 << 16, C0  = 37'd1 << 22;
   localparam logic [36:0] ENB  = 37'd1 << 23, EAA  = 37'd1 << 24, EALU = 37'd1 << 25;
   localparam logic [36:0] MR   = 37'd1 << 26, MW   = 37'd1 << 27, SZ  = 37'd3 << 28;
   localparam logic [36:0] SL   = 37'd1 << 30, PCS  = 37'd1 << 31, EAP = 37'd1 << 32;
   localparam logic [36:0] IL   = 37'd1 << 34, PS01 = 37'd1 << 35, PS11 = 37'd3 << 35;
   localparam logic [36:0] FADD = 37'(5'b01000) << 17, FSUB = 37'(5'b01001) << 17;
   localparam logic [36:0] FW   = EAP | MR | SZ, FG = FW | IL | PS01;
   localparam logic [63:0] M8   = 64'hFFFF_FFFF_FFFF_FFF8;

   control_sequencer dut (
      .clock(clock), .reset(reset), .instruction(instruction), .status(status),
      .mem_ready(mem_ready), .control_word(control_word), .constant(constant),
      .state(state), .halted(halted)
   );

   always #5 clock = ~clock;

   function automatic logic [36:0] regs(input int da, input int sa, input int sb);
      return 37'(da) | (37'(sa) << 5) | (37'(sb) << 10);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clock);
      #2;
   endtask

   task automatic look(input string tag, input logic [2:0] st, input logic [36:0] cw, input logic [63:0] k);
      #1;
      chk({tag, ".state"}, 64'(state), 64'(st));
      chk({tag, ".cw"}, 64'(control_word), 64'(cw));
      chk({tag, ".const"}, constant, k);
   endtask

   task automatic fetch_decode(input logic [31:0] ins);
      instruction = ins;
      mem_ready = 1'b1;
      look("fetch", 3'd0, FG, 64'd0);
      cyc;
      mem_ready = 1'b0;
      look("decode", 3'd1, 37'd0, 64'd0);
      cyc;
   endtask

   initial begin
      #2;
      look("reset", 3'd0, 37'd0, 64'd0);
      chk("reset.halted", 64'(halted), 64'd0);
      reset = 1'b1;
      instruction = 32'hF85F80C5;
      look("fetch_wait", 3'd0, FW, 64'd0);
      cyc;
      look("fetch_wait2", 3'd0, FW, 64'd0);
      fetch_decode(32'hF85F80C5);
      look("ldur_w1", 3'd2, regs(5, 6, 0) | BSEL | FADD | EAA | MR | SZ, M8);
      cyc;
      look("ldur_w2", 3'd2, regs(5, 6, 0) | BSEL | FADD | EAA | MR | SZ, M8);
      reset = 1'b0;
      look("abort", 3'd0, 37'd0, 64'd0);
      cyc;
      reset = 1'b1;
      look("post_abort", 3'd0, FW, 64'd0);
      fetch_decode(32'hF85F80C5);
      for (int i = 0; i < 3; i++) begin
         look("ldur_wait", 3'd2, regs(5, 6, 0) | BSEL | FADD | EAA | MR | SZ, M8);
         cyc;
      end
      mem_ready = 1'b1;
      look("ldur_done", 3'd2, regs(5, 6, 0) | BSEL | FADD | EAA | MR | SZ | WR, M8);
      cyc;
      mem_ready = 1'b0;
      look("ldur_back", 3'd0, FW, 64'd0);
      fetch_decode(32'h8B020023);
      look("add", 3'd2, regs(3, 1, 2) | WR | FADD | EALU | SL, 64'd0);
      cyc;
      look("add_back", 3'd0, FW, 64'd0);
      fetch_decode(32'hCB020023);
      look("sub", 3'd2, regs(3, 1, 2) | WR | FSUB | C0 | EALU | SL, 64'd0);
      cyc;
      fetch_decode(32'h913FFC41);
      look("addi", 3'd2, regs(1, 2, 0) | BSEL | WR | FADD | EALU | SL, 64'h0FFF);
      cyc;
      fetch_decode(32'hF8010089);
      look("stur_wait", 3'd2, regs(0, 4, 9) | BSEL | FADD | EAA | ENB | MW | SZ, 64'd16);
      cyc;
      mem_ready = 1'b1;
      look("stur_done", 3'd2, regs(0, 4, 9) | BSEL | FADD | EAA | ENB | MW | SZ, 64'd16);
      cyc;
      mem_ready = 1'b0;
      look("stur_back", 3'd0, FW, 64'd0);
      fetch_decode(32'h17FFFFFF);
      look("b", 3'd2, PCS | PS11, M8);
      cyc;
      look("b_back", 3'd0, FW, 64'd0);
      fetch_decode(32'hB4000047);
      look("cbz", 3'd2, regs(0, 7, 0) | BSEL | FADD | SL, 64'd0);
      cyc;
      status = 4'b0001;
      look("cbz_taken", 3'd3, PCS | PS11, 64'd4);
      cyc;
      look("cbz_back", 3'd0, FW, 64'd0);
      fetch_decode(32'hB4000047);
      cyc;
      status = 4'b1110;
      look("cbz_not", 3'd3, 37'd0, 64'd0);
      cyc;
      look("cbz_not_back", 3'd0, FW, 64'd0);
      fetch_decode(32'h00000000);
      for (int i = 0; i < 4; i++) begin
         mem_ready = i[0];
         look("halt", 3'd4, 37'd0, 64'd0);
         chk("halt.halted", 64'(halted), 64'd1);
         cyc;
      end
      reset = 1'b0;
      look("halt_reset", 3'd0, 37'd0, 64'd0);
      chk("halt_reset.halted", 64'(halted), 64'd0);
      cyc;
      reset = 1'b1;
      mem_ready = 1'b0;
      look("restart", 3'd0, FW, 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 64-bit LEGv8 datapath.
- Drives the 37-bit datapath control word and the 64-bit constant bus.
- Reads the instruction register output and the 4-bit latched ALU status.
- Handshakes with memory via mem_ready.
- Supports ADD, SUB, ADDI, LDUR, STUR, B and CBZ. Any other opcode halts the core.

Parameters:
- FS_ADD, 5'b01000, ALU function code for A+B (C0=0).
- FS_SUB, 5'b01001, ALU function code for A-B (C0=1).
- Z_BIT, 0, index of the zero flag within status.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction register output.
- status  in  4  latched ALU status.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- control_word  out  37  datapath control.
- constant  out  64  immediate / branch offset to the datapath.
- state  out  3  current FSM state (debug).
- halted  out  1  set in HALT.

Behaviour:
- Control word fields: DA[4:0], SA[9:5], SB[14:10], WR[15], Bsel[16], FS[21:17], C0[22], En_B[23], En_ADDR_ALU[24], En_ALU[25], mem_read[26], mem_write[27], size[29:28], Status_load[30], PCsel[31], EN_ADDR_PC[32], EN_PC[33], IL[34], PS[36:35].
- PS codes: 00 hold, 01 PC+4, 10 PC<=in, 11 PC<=PC+in.
- States: FETCH=0, DECODE=1, EXEC=2, BRANCH=3, HALT=4. Only the state register is sequential. control_word, constant and halted are combinational from state, instruction, status and mem_ready.
- Reset (reset low, asynchronous): state=FETCH; control_word=0, constant=0, halted=0 while reset is low. Reset mid-operation aborts immediately, with no partial write asserted.
- Every field not named below is 0. Unused constant is 0.
- FETCH:
  - EN_ADDR_PC=1, mem_read=1, size=11.
  - If mem_ready: IL=1, PS=01, next DECODE. Otherwise IL=0, PS=00, stay in FETCH (wait is unbounded).
- DECODE: control_word=0. Opcode classification, first match wins:
  - [31:21]=10001011000 ADD
  - [31:21]=11001011000 SUB
  - [31:22]=1001000100 ADDI
  - [31:21]=11111000010 LDUR
  - [31:21]=11111000000 STUR
  - [31:26]=000101 B
  - [31:24]=10110100 CBZ
  - Match -> EXEC; no match -> HALT.
- EXEC, ADD/SUB:
  - DA=[4:0], SA=[9:5], SB=[20:16], FS=FS_ADD or FS_SUB, C0 per FS.
  - En_ALU=1, WR=1, Status_load=1. One cycle, then FETCH.
- EXEC, ADDI: as ADD with Bsel=1, constant=zero-extend [21:10]; SB=0.
- EXEC, LDUR:
  - SA=[9:5], DA=[4:0], Bsel=1, constant=sign-extend [20:12], FS=FS_ADD.
  - En_ADDR_ALU=1, mem_read=1, size=11, WR=mem_ready.
  - Stay in EXEC until mem_ready, then FETCH.
- EXEC, STUR:
  - SA=[9:5], SB=[4:0], Bsel=1, constant=sign-extend [20:12], FS=FS_ADD.
  - En_ADDR_ALU=1, En_B=1, mem_write=1, size=11.
  - Held until mem_ready, then FETCH. WR=0 always.
- EXEC, B:
  - PCsel=1, PS=11, constant=(sign-extend [25:0] << 2) - 4 (compensates the fetch increment).
  - One cycle, then FETCH.
- EXEC, CBZ:
  - SA=[4:0], Bsel=1, constant=0, FS=FS_ADD, Status_load=1.
  - Next BRANCH.
- BRANCH:
  - If status[Z_BIT]=1: PCsel=1, PS=11, constant=(sign-extend [23:5] << 2) - 4.
  - Else: PS=00.
  - Next FETCH.
- HALT: control_word=0, halted=1. Left only by reset.
- Arithmetic: constants are 64-bit two's complement; the subtraction of 4 wraps modulo 2^64.
- mem_ready is ignored in DECODE, BRANCH and HALT, and for non-memory EXEC cases.

Test Plan:
- Reset, then hold reset low mid-LDUR with mem_ready=0 -> control_word=0, state=0; after release the first cycle shows FETCH with mem_read=1, EN_ADDR_PC=1, IL=0.
- Fetch ADD X3,X1,X2 (0x8B020023) with mem_ready high in FETCH -> DECODE then EXEC: DA=3, SA=1, SB=2, WR=1, En_ALU=1, FS=FS_ADD. Total 3 cycles back to FETCH.
- LDUR X5,[X6,#-8] (0xF85F80C5) with mem_ready low for 3 EXEC cycles -> constant=0xFFFF_FFFF_FFFF_FFF8, WR=0 during the wait, WR=1 only in the mem_ready cycle.
- B with imm26=-1 (0x17FFFFFF) -> PS=11, PCsel=1, constant=0xFFFF_FFFF_FFFF_FFF8.
- CBZ X7,+2 (0xB4000047): status Z=1 in BRANCH -> PS=11, constant=4; repeat with Z=0 -> PS=00.
- Undefined opcode 0x00000000 -> HALT after DECODE, halted=1, control_word=0 indefinitely until reset.
